// File: rtl/morse_tx_sequencer.sv
// Replays the Morse character buffer onto Y: fetch {len, pattern}, shift MSB-first
// one bit per Tick, then hold a fixed silent gap before the next character.
module morse_tx_sequencer #(
   parameter int ADDR_W    = 4,
   parameter int PAT_W     = 22,
   parameter int LEN_W     = 5,
   parameter int GAP_UNITS = 3
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   Start,
   input  logic                   Tick,
   input  logic [ADDR_W-1:0]      Num_Chars,
   input  logic [LEN_W+PAT_W-1:0] Rd_Data,
   output logic [ADDR_W-1:0]      Rd_Addr,
   output logic                   Y,
   output logic                   Busy,
   output logic                   Done
);

   localparam int GAP_W = 4;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] last_idx_q, last_idx_d;
   logic [PAT_W-1:0]  shreg_q, shreg_d;
   logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              y_q, y_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [LEN_W-1:0]  rd_len;
   assign rd_len = Rd_Data[LEN_W+PAT_W-1:PAT_W];

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      last_idx_d = last_idx_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      y_d        = y_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (Num_Chars != '0) begin
                  last_idx_d = Num_Chars - ADDR_W'(1);
                  rd_addr_d  = '0;
                  busy_d     = 1'b1;
                  state_d    = S_ADDR;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ADDR: state_d = S_LOAD;
         S_LOAD: begin
            shreg_d   = Rd_Data[PAT_W-1:0];
            // Lengths beyond the pattern field are clamped to the field width.
            bit_cnt_d = (32'(rd_len) > PAT_W) ? LEN_W'(PAT_W) : rd_len;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (Tick) begin
               if (bit_cnt_q != '0) begin
                  y_d       = shreg_q[PAT_W-1];
                  shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - LEN_W'(1);
               end else begin
                  // End Tick counts as the first silent unit of the gap.
                  y_d = 1'b0;
                  if (rd_addr_q == last_idx_q) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end else if (GAP_UNITS == 1) begin
                     rd_addr_d = rd_addr_q + ADDR_W'(1);
                     state_d   = S_ADDR;
                  end else begin
                     gap_cnt_d = GAP_W'(GAP_UNITS - 1);
                     state_d   = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (Tick) begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
               if (gap_cnt_q == GAP_W'(1)) begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                  state_d   = S_ADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         last_idx_q <= '0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         y_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         last_idx_q <= last_idx_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         y_q        <= y_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Rd_Addr = rd_addr_q;
   assign Y       = y_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule
